// File: rtl/spixel_probe_if.sv
// Query handshake and frame-buffer read port bundle for spixel_probe.
// slave = probe side, master = requester / RAM side.
interface spixel_probe_if #(
  parameter int SPIXEL_X_WIDTH = 5,
  parameter int SPIXEL_Y_WIDTH = 5,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 8
);
  logic [SPIXEL_X_WIDTH-1:0] x;
  logic [SPIXEL_Y_WIDTH-1:0] y;
  logic                      ireq;
  logic                      obusy;
  logic [DATA_WIDTH-1:0]     odata;
  logic                      odone;
  logic                      oerr;
  logic                      omixed;
  logic [ADDR_WIDTH-1:0]     oaddr;
  logic                      orden;
  logic [DATA_WIDTH-1:0]     irdata;

  modport master (
    output x, y, ireq, irdata,
    input  obusy, odata, odone, oerr,
    input  omixed, oaddr, orden
  );

  modport slave (
    input  x, y, ireq, irdata,
    output obusy, odata, odone, oerr,
    output omixed, oaddr, orden
  );
endinterface

// File: rtl/spixel_probe.sv
// Superpixel colour probe: reads a cell back from the frame-buffer RAM.
// Define SPIXEL_PROBE_SCAN_EN to scan the whole cell and report omixed.
module spixel_probe #(
  parameter int SPIXEL_X_WIDTH = 5,
  parameter int SPIXEL_Y_WIDTH = 5,
  parameter int SPIXEL_X_MAX   = 31,
  parameter int SPIXEL_Y_MAX   = 23,
  parameter int PIXEL_X_WIDTH  = 10,
  parameter int PIXEL_Y_WIDTH  = 9,
  parameter int PIXEL_X_MAX    = 639,
  parameter int PIXEL_Y_MAX    = 479,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 8,
  parameter int RD_LATENCY     = 2
) (
  input logic           clk,
  input logic           rst,
  spixel_probe_if.slave bus
);
  localparam int PW = PIXEL_X_MAX + 1;
  localparam int SW = PW / (SPIXEL_X_MAX + 1);
  localparam int SH = (PIXEL_Y_MAX + 1) / (SPIXEL_Y_MAX + 1);
`ifdef SPIXEL_PROBE_SCAN_EN
  localparam int NPIX = SW * SH;
`else
  localparam int NPIX = 1;
`endif
  localparam int TW = $clog2(NPIX + RD_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           t_q, t_d;
  logic                    obusy_q, obusy_d;
  logic                    odone_q, odone_d;
  logic                    oerr_q, oerr_d;
  logic                    orden_q, orden_d;
  logic [ADDR_WIDTH-1:0]   oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0]   odata_q, odata_d;

  logic [SPIXEL_X_WIDTH-1:0] x_in;
  logic [SPIXEL_Y_WIDTH-1:0] y_in;
  logic [PIXEL_X_WIDTH-1:0]  px;
  logic [PIXEL_Y_WIDTH-1:0]  py;
  logic [ADDR_WIDTH-1:0]     tl;
  logic                      in_range;
  logic                      samp;
  logic                      last;
  logic                      issue_last;
  logic [DATA_WIDTH-1:0]     first_pix;

`ifdef SPIXEL_PROBE_SCAN_EN
  localparam int CW = $clog2(SW) + 1;
  logic [CW-1:0]           col_q, col_d;
  logic [ADDR_WIDTH-1:0]   row_q, row_d;
  logic [DATA_WIDTH-1:0]   first_q, first_d;
  logic                    mix_q, mix_d;
  logic                    omixed_q, omixed_d;
  logic                    mix_now;
  logic                    m0;
`endif

  assign x_in = bus.x;
  assign y_in = bus.y;
  assign px = PIXEL_X_WIDTH'(32'(x_in) * 32'(SW));
  assign py = PIXEL_Y_WIDTH'(32'(y_in) * 32'(SH));
  assign tl = ADDR_WIDTH'(32'(py) * 32'(PW) + 32'(px));

  assign in_range = (32'(x_in) <= 32'(SPIXEL_X_MAX))
                 && (32'(y_in) <= 32'(SPIXEL_Y_MAX));

  // t counts cycles since the first issue; pixel m lands at t == RD+m
  assign samp = 32'(t_q) >= 32'(RD_LATENCY);
  assign last = 32'(t_q) == 32'(RD_LATENCY + NPIX - 1);
  assign issue_last = 32'(t_q) == 32'(NPIX - 1);

`ifdef SPIXEL_PROBE_SCAN_EN
  assign m0 = 32'(t_q) == 32'(RD_LATENCY);
  assign first_pix = m0 ? bus.irdata : first_q;
  assign mix_now = m0 ? 1'b0
                 : (mix_q | (bus.irdata != first_q));
`else
  assign first_pix = bus.irdata;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    oerr_d  = oerr_q;
    orden_d = orden_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
`ifdef SPIXEL_PROBE_SCAN_EN
    col_d    = col_q;
    row_d    = row_q;
    first_d  = first_q;
    mix_d    = mix_q;
    omixed_d = omixed_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.ireq) begin
          t_d = '0;
          if (in_range) begin
            state_d = S_ISSUE;
            orden_d = 1'b1;
            oaddr_d = tl;
`ifdef SPIXEL_PROBE_SCAN_EN
            col_d = '0;
            row_d = tl;
`endif
          end else begin
            state_d = S_DONE;
            oerr_d  = 1'b1;
            odata_d = '0;
`ifdef SPIXEL_PROBE_SCAN_EN
            omixed_d = 1'b0;
`endif
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        t_d = t_q + TW'(1);
        if (state_q == S_ISSUE) begin
          if (issue_last) begin
            orden_d = 1'b0;
            state_d = S_WAIT;
          end
`ifdef SPIXEL_PROBE_SCAN_EN
          else if (32'(col_q) == 32'(SW - 1)) begin
            col_d   = '0;
            row_d   = row_q + ADDR_WIDTH'(PW);
            oaddr_d = row_q + ADDR_WIDTH'(PW);
          end else begin
            col_d   = col_q + CW'(1);
            oaddr_d = oaddr_q + ADDR_WIDTH'(1);
          end
`endif
        end
        if (samp) begin
`ifdef SPIXEL_PROBE_SCAN_EN
          first_d = first_pix;
          mix_d   = mix_now;
`endif
          if (last) begin
            state_d = S_DONE;
            odata_d = first_pix;
            oerr_d  = 1'b0;
`ifdef SPIXEL_PROBE_SCAN_EN
            omixed_d = mix_now;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    obusy_d = (state_d == S_ISSUE)
           || (state_d == S_WAIT);
    odone_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      obusy_q <= 1'b0;
      odone_q <= 1'b0;
      oerr_q  <= 1'b0;
      orden_q <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
`ifdef SPIXEL_PROBE_SCAN_EN
      col_q    <= '0;
      row_q    <= '0;
      first_q  <= '0;
      mix_q    <= 1'b0;
      omixed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      obusy_q <= obusy_d;
      odone_q <= odone_d;
      oerr_q  <= oerr_d;
      orden_q <= orden_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
`ifdef SPIXEL_PROBE_SCAN_EN
      col_q    <= col_d;
      row_q    <= row_d;
      first_q  <= first_d;
      mix_q    <= mix_d;
      omixed_q <= omixed_d;
`endif
    end
  end

  assign bus.obusy = obusy_q;
  assign bus.odone = odone_q;
  assign bus.oerr  = oerr_q;
  assign bus.orden = orden_q;
  assign bus.oaddr = oaddr_q;
  assign bus.odata = odata_q;
`ifdef SPIXEL_PROBE_SCAN_EN
  assign bus.omixed = omixed_q;
`else
  assign bus.omixed = 1'b0;
`endif
endmodule

// File: tb/tb_spixel_probe.sv
// Randomised self-checking bench for spixel_probe with a RAM model.
// Expected values come from cell geometry and RAM contents.
module tb_spixel_probe;
  localparam int RD = 2;
  localparam int SW = 20;
  localparam int SH = 20;
  localparam int PW = 640;
`ifdef SPIXEL_PROBE_SCAN_EN
  localparam int NPIX = SW * SH;
`else
  localparam int NPIX = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spixel_probe_if bus ();

  spixel_probe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:(1<<19)-1];
  logic [7:0] pipe [0:RD-1];

  always @(posedge clk) begin
    pipe[0] <= bus.orden ? mem[bus.oaddr] : 8'($urandom);
    for (int i = 1; i < RD; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.irdata = pipe[RD-1];

  int n_cmp = 0;
  int n_bad = 0;
  int addrs[$];
  int r_lat, r_nrd, r_first_c;
  bit r_busy_ok, r_wide, r_idle_after;
  logic [7:0] r_data;
  logic r_err, r_mix;

  function automatic int top_left(int qx, int qy);
    return qy * SH * PW + qx * SW;
  endfunction

  function automatic bit valid_xy(int qx, int qy);
    return qx <= 31 && qy <= 23;
  endfunction

  function automatic logic model_mixed(int qx, int qy);
    logic m;
    int t;
    m = 1'b0;
`ifdef SPIXEL_PROBE_SCAN_EN
    t = top_left(qx, qy);
    for (int j = 0; j < SH; j++)
      for (int i = 0; i < SW; i++)
        if (mem[t + j*PW + i] != mem[t]) m = 1'b1;
`else
    t = qx + qy;
`endif
    return m;
  endfunction

  task automatic fill_cell(int qx, int qy, logic [7:0] base,
                           int odd, logic [7:0] odd_val);
    int t;
    t = top_left(qx, qy);
    for (int j = 0; j < SH; j++)
      for (int i = 0; i < SW; i++)
        mem[t + j*PW + i] = base;
    if (odd >= 0) mem[t + (odd/SW)*PW + odd%SW] = odd_val;
  endtask

  task automatic do_query(int qx, int qy, bit hold);
    addrs.delete();
    r_nrd = 0; r_first_c = -1; r_busy_ok = 1; r_lat = -1;
    r_data = 'x; r_err = 'x; r_mix = 'x;
    @(negedge clk);
    bus.x = 5'(qx); bus.y = 5'(qy); bus.ireq = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (!hold) bus.ireq = 1'b0;
      else begin
        bus.x = 5'($urandom); bus.y = 5'($urandom);
      end
      if (bus.orden) begin
        addrs.push_back(int'(bus.oaddr));
        r_nrd++;
        if (r_first_c < 0) r_first_c = c;
      end
      if (bus.odone) begin
        r_lat = c - 1;
        r_data = bus.odata; r_err = bus.oerr; r_mix = bus.omixed;
        if (bus.obusy) r_busy_ok = 0;
        break;
      end
      if (!bus.obusy) r_busy_ok = 0;
    end
    bus.ireq = 1'b0;
    @(negedge clk);
    r_wide = bus.odone;
    r_idle_after = !bus.obusy && !bus.orden;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.obusy, bus.odone, bus.oerr, bus.omixed, bus.orden} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
        {bus.obusy, bus.odone, bus.oerr, bus.omixed, bus.orden});
    if ({bus.obusy, bus.odone, bus.oerr, bus.omixed, bus.orden} !== 5'b0)
      n_bad++;
    n_cmp++;
    if (bus.odata !== 8'h0 || bus.oaddr !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_data: odata=%0h oaddr=%0h want 0 0",
        bus.odata, bus.oaddr);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fill_cell(1, 0, 8'h0f, -1, 8'h00);
    do_query(1, 0, 0);
    n_cmp++;
    if (r_nrd != NPIX) begin
      n_bad++; $display("FAIL basic_nrd: got %0d want %0d", r_nrd, NPIX);
    end
    n_cmp++;
    if (addrs.size() == 0 || addrs[0] != 20 || r_first_c != 1) begin
      n_bad++;
      $display("FAIL basic_addr: got n=%0d c=%0d want addr 20 c=1",
        addrs.size(), r_first_c);
    end
    n_cmp++;
    if (r_lat != NPIX + RD) begin
      n_bad++; $display("FAIL basic_lat: got %0d want %0d", r_lat, NPIX+RD);
    end
    n_cmp++;
    if (r_data !== 8'h0f || r_err !== 1'b0 || r_mix !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_out: got d=%0h e=%b m=%b want 0f 0 0",
        r_data, r_err, r_mix);
    end
    n_cmp++;
    if (!r_busy_ok || r_wide) begin
      n_bad++;
      $display("FAIL basic_busy: got busy_ok=%0d wide=%0d want 1 0",
        r_busy_ok, r_wide);
    end
  endtask

  task automatic test_corners();
    fill_cell(31, 23, 8'hf9, -1, 8'h00);
    do_query(31, 23, 0);
    n_cmp++;
    if (addrs.size() == 0 || addrs[0] != 295020 || r_data !== 8'hf9) begin
      n_bad++;
      $display("FAIL corner_max: got n=%0d d=%0h want 295020 f9",
        addrs.size(), r_data);
    end
    fill_cell(0, 1, 8'h21, -1, 8'h00);
    do_query(0, 1, 0);
    n_cmp++;
    if (addrs.size() == 0 || addrs[0] != 12800 || r_data !== 8'h21) begin
      n_bad++;
      $display("FAIL corner_row1: got n=%0d d=%0h want 12800 21",
        addrs.size(), r_data);
    end
  endtask

  task automatic test_error();
    do_query(31, 24, 0);
    n_cmp++;
    if (r_nrd != 0 || r_lat != 0) begin
      n_bad++;
      $display("FAIL err_access: got nrd=%0d lat=%0d want 0 0",
        r_nrd, r_lat);
    end
    n_cmp++;
    if (r_err !== 1'b1 || r_data !== 8'h0 || r_wide) begin
      n_bad++;
      $display("FAIL err_out: got e=%b d=%0h wide=%0d want 1 0 0",
        r_err, r_data, r_wide);
    end
  endtask

  task automatic test_hold();
    fill_cell(5, 7, 8'h77, -1, 8'h00);
    do_query(5, 7, 1);
    n_cmp++;
    if (r_nrd != NPIX || addrs.size() == 0
        || addrs[0] != top_left(5, 7)) begin
      n_bad++;
      $display("FAIL hold_addr: got nrd=%0d want %0d", r_nrd, NPIX);
    end
    n_cmp++;
    if (r_lat != NPIX + RD || r_data !== 8'h77 || !r_idle_after) begin
      n_bad++;
      $display("FAIL hold_ignore: got lat=%0d d=%0h idle=%0d want %0d 77 1",
        r_lat, r_data, r_idle_after, NPIX+RD);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    bit seen;
    fill_cell(3, 4, 8'h3c, -1, 8'h00);
    fill_cell(10, 2, 8'hc3, -1, 8'h00);
    @(negedge clk);
    bus.x = 5'd3; bus.y = 5'd4; bus.ireq = 1'b1;
    @(negedge clk);
    bus.ireq = 1'b0;
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      if (bus.odone) begin seen = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || bus.odata !== 8'h3c) begin
      n_bad++;
      $display("FAIL b2b_first: got seen=%0d d=%0h want 1 3c",
        seen, bus.odata);
    end
    bus.x = 5'd10; bus.y = 5'd2; bus.ireq = 1'b1;
    @(negedge clk);
    bus.ireq = 1'b0;
    n_cmp++;
    if ({bus.odone, bus.orden, bus.obusy} !== 3'b011) begin
      n_bad++;
      $display("FAIL b2b_accept: got done,rden,busy=%b want 011",
        {bus.odone, bus.orden, bus.obusy});
    end
    n_cmp++;
    if (bus.oaddr !== 19'(top_left(10, 2))) begin
      n_bad++;
      $display("FAIL b2b_addr: got %0d want %0d",
        bus.oaddr, top_left(10, 2));
    end
    c = 1; seen = 0;
    while (c < 1000) begin
      @(negedge clk); c++;
      if (bus.odone) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen || c - 1 != NPIX + RD || bus.odata !== 8'hc3) begin
      n_bad++;
      $display("FAIL b2b_second: got lat=%0d d=%0h want %0d c3",
        c - 1, bus.odata, NPIX+RD);
    end
  endtask

  task automatic test_reset_mid();
    int c, cnt;
    fill_cell(6, 6, 8'h5a, -1, 8'h00);
    fill_cell(7, 8, 8'ha5, -1, 8'h00);
    do_query(6, 6, 0);
    @(negedge clk);
    bus.x = 5'd7; bus.y = 5'd8; bus.ireq = 1'b1;
    @(negedge clk);
    bus.ireq = 1'b0;
    c = 1;
    while (c < NPIX + 1) begin @(negedge clk); c++; end
    n_cmp++;
    if (bus.obusy !== 1'b1 || bus.orden !== 1'b0 || bus.odata !== 8'h5a) begin
      n_bad++;
      $display("FAIL rmid_pre: got busy=%b rden=%b d=%0h want 1 0 5a",
        bus.obusy, bus.orden, bus.odata);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.obusy, bus.odone, bus.oerr, bus.omixed, bus.orden} !== 5'b0
        || bus.odata !== 8'h0 || bus.oaddr !== 19'h0) begin
      n_bad++;
      $display("FAIL rmid_clear: got flags=%b d=%0h a=%0h want 0",
        {bus.obusy, bus.odone, bus.oerr, bus.omixed, bus.orden},
        bus.odata, bus.oaddr);
    end
    rst = 1'b0;
    cnt = 0;
    repeat (NPIX + RD + 6) begin
      @(negedge clk);
      if (bus.odone || bus.obusy) cnt++;
    end
    n_cmp++;
    if (cnt != 0) begin
      n_bad++; $display("FAIL rmid_nodone: got %0d active cycles want 0", cnt);
    end
    do_query(7, 8, 0);
    n_cmp++;
    if (r_lat != NPIX + RD || r_data !== 8'ha5 || r_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_after: got lat=%0d d=%0h e=%b want %0d a5 0",
        r_lat, r_data, r_err, NPIX+RD);
    end
  endtask

  task automatic test_scan();
`ifdef SPIXEL_PROBE_SCAN_EN
    fill_cell(2, 3, 8'h0f, 137, 8'hff);
    do_query(2, 3, 0);
    n_cmp++;
    if (r_nrd != 400 || r_data !== 8'h0f || r_mix !== 1'b1) begin
      n_bad++;
      $display("FAIL scan_mixed: got n=%0d d=%0h m=%b want 400 0f 1",
        r_nrd, r_data, r_mix);
    end
    fill_cell(2, 3, 8'h0f, -1, 8'h00);
    do_query(2, 3, 0);
    n_cmp++;
    if (r_nrd != 400 || r_data !== 8'h0f || r_mix !== 1'b0) begin
      n_bad++;
      $display("FAIL scan_uniform: got n=%0d d=%0h m=%b want 400 0f 0",
        r_nrd, r_data, r_mix);
    end
`endif
  endtask

  task automatic test_random();
    int qx, qy, t, bad;
    bit ok;
    logic [7:0] base, ed;
    logic em;
    for (int it = 0; it < 24; it++) begin
      qx = $urandom_range(0, 31);
      qy = $urandom_range(0, 25);
      ok = valid_xy(qx, qy);
      t = top_left(qx, qy);
      if (ok) begin
        base = 8'($urandom);
        if ($urandom_range(0, 1) == 1)
          fill_cell(qx, qy, base, $urandom_range(1, SW*SH-1),
                    base ^ 8'($urandom_range(1, 255)));
        else
          fill_cell(qx, qy, base, -1, 8'h00);
      end
      ed = ok ? mem[t] : 8'h00;
      em = ok ? model_mixed(qx, qy) : 1'b0;
      do_query(qx, qy, 0);
      bad = 0;
      if (addrs.size() != (ok ? NPIX : 0)) bad++;
      else
        for (int k = 0; k < addrs.size(); k++)
          if (addrs[k] != t + (k/SW)*PW + k%SW) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL rnd_addr(%0d,%0d): got %0d bad of %0d want 0",
          qx, qy, bad, addrs.size());
      end
      n_cmp++;
      if (r_lat != (ok ? NPIX + RD : 0) || r_wide
          || (ok && r_first_c != 1) || !(ok ? r_busy_ok : 1'b1)) begin
        n_bad++;
        $display("FAIL rnd_timing(%0d,%0d): got lat=%0d c=%0d busy=%0d",
          qx, qy, r_lat, r_first_c, r_busy_ok);
      end
      n_cmp++;
      if (r_data !== ed || r_err !== !ok || r_mix !== em) begin
        n_bad++;
        $display("FAIL rnd_out(%0d,%0d): got %0h/%b/%b want %0h/%b/%b",
          qx, qy, r_data, r_err, r_mix, ed, !ok, em);
      end
    end
  endtask

  initial begin
    bus.x = '0; bus.y = '0; bus.ireq = 1'b0;
    for (int i = 0; i < (1<<19); i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_corners();
    test_error();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end
endmodule
